keypad_duty_ctrl: RTL and testbench

KEYPAD_DUTY_CTRL -- requirements
Module: keypad_duty_ctrl

---
 rtl/keypad_duty_ctrl.sv | 139 +++++++++++++
 tb/tb_keypad_duty_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_duty_ctrl.sv
// Debounces a single-key keypad pattern and maps each press onto an 8-bit PWM duty value.
// Digits set duty directly; '#'/'*' step it up/down with saturation.
module keypad_duty_ctrl #(
    parameter logic [15:0] DEBOUNCE = 16'd1000,
    parameter logic [7:0]  STEP     = 8'd16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] keys,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        held,
    output logic [7:0]  duty
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [11:0] cap, cap_n;
    logic        fire;
    logic        one_hot;
    logic [3:0]  idx_n;
    logic [7:0]  duty_n;
    logic [8:0]  sum9;
    logic [8:0]  diff9;
    logic [7:0]  digit_duty;

    assign one_hot = (keys != '0) && ((keys & (keys - 12'd1)) == '0);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cap_n   = cap;
        fire    = 1'b0;
        case (state)
            S_IDLE: begin
                if (one_hot) begin
                    cap_n = keys;
                    if (DEBOUNCE == 16'd1) begin
                        state_n = S_PRESSED;
                        cnt_n   = '0;
                        fire    = 1'b1;
                    end else begin
                        state_n = S_DEBOUNCE;
                        cnt_n   = 16'd1;
                    end
                end
            end
            S_DEBOUNCE: begin
                if (keys != cap) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                    if (cnt_n == DEBOUNCE) begin
                        state_n = S_PRESSED;
                        cnt_n   = '0;
                        fire    = 1'b1;
                    end
                end
            end
            S_PRESSED: begin
                if (keys == '0) begin
                    if (DEBOUNCE == 16'd1) begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end else begin
                        state_n = S_RELEASE;
                        cnt_n   = 16'd1;
                    end
                end
            end
            S_RELEASE: begin
                if (keys != '0) begin
                    state_n = S_PRESSED;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                    if (cnt_n == DEBOUNCE) begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Index is taken from cap_n so a DEBOUNCE==1 press out of IDLE reports the new key.
    always_comb begin
        idx_n = '0;
        for (int unsigned i = 0; i < 12; i++) begin
            if (cap_n[i]) idx_n = 4'(i);
        end
    end

    assign sum9       = {1'b0, duty} + {1'b0, STEP};
    assign diff9      = {1'b0, duty} - {1'b0, STEP};
    assign digit_duty = {4'b0, idx_n} * 8'd28;

    always_comb begin
        duty_n = duty;
        if (fire) begin
            if (idx_n <= 4'd9)       duty_n = digit_duty;
            else if (idx_n == 4'd10) duty_n = diff9[8] ? 8'd0 : diff9[7:0];
            else                     duty_n = sum9[8] ? 8'd255 : sum9[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cap       <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            held      <= 1'b0;
            duty      <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cap       <= cap_n;
            key_valid <= fire;
            if (fire) key_code <= idx_n;
            held      <= (state_n == S_PRESSED) || (state_n == S_RELEASE);
            duty      <= duty_n;
        end
    end

endmodule

// File: tb/tb_keypad_duty_ctrl.sv
// Scoreboard bench for keypad_duty_ctrl at DEBOUNCE=4, STEP=16.
// Stimulus queues the expected (code, duty, cycle) per press; a negedge monitor checks each key_valid.
module tb_keypad_duty_ctrl;

    logic        clock;
    logic        reset;
    logic [11:0] keys;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        held;
    logic [7:0]  duty;

    typedef struct {
        logic [3:0]  code;
        logic [7:0]  duty;
        int unsigned cyc;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc;
    int          tests;
    int          fails;

    keypad_duty_ctrl #(
        .DEBOUNCE(16'd4),
        .STEP(8'd16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .keys(keys),
        .key_valid(key_valid),
        .key_code(key_code),
        .held(held),
        .duty(duty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input int code, input logic [7:0] d, input int unsigned at);
        exp_t e;
        e.code = 4'(code);
        e.duty = d;
        e.cyc  = at;
        q.push_back(e);
    endtask

    // Press one key for `hold` cycles, then release long enough for the release debounce.
    task automatic press(input int code, input int hold, input logic [7:0] exp_duty);
        keys = 12'd1 << code;
        push(code, exp_duty, cyc + 4);
        tick(hold);
        keys = '0;
        tick(8);
    endtask

    always @(negedge clock) begin
        if (reset === 1'b1 && key_valid === 1'b1) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_key_valid: got key_code %0d duty %0d with nothing expected (cycle %0d)",
                         key_code, duty, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("key_code", 32'(key_code), 32'(e.code));
                check("duty", 32'(duty), 32'(e.duty));
                check("event_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned k;
        tests = 0;
        fails = 0;
        reset = 1'b0;
        keys  = '0;
        tick(2);
        check("rst_key_valid", 32'(key_valid), 0);
        check("rst_key_code", 32'(key_code), 0);
        check("rst_held", 32'(held), 0);
        check("rst_duty", 32'(duty), 0);
        reset = 1'b1;
        tick(3);

        // Key 5 for 4 cycles then release: event in cycle 4, held through 4 release cycles.
        keys = 12'h020;
        k = cyc;
        push(5, 8'd140, k + 4);
        tick(4);
        keys = '0;
        @(negedge clock);
        check("held_at_event", 32'(held), 1);
        tick(3);
        @(negedge clock);
        check("held_release_last", 32'(held), 1);
        tick(1);
        @(negedge clock);
        check("held_after_release", 32'(held), 0);
        tick(4);

        // Too-short press: no event.
        keys = 12'h020;
        tick(3);
        keys = '0;
        @(negedge clock);
        check("short_held", 32'(held), 0);
        tick(4);
        check("short_duty", 32'(duty), 140);

        // Two keys at once are not a valid pattern.
        keys = 12'h021;
        tick(10);
        @(negedge clock);
        check("two_keys_held", 32'(held), 0);
        check("two_keys_duty", 32'(duty), 140);
        keys = '0;
        tick(4);

        // Saturation walk.
        press(9, 5, 8'd252);
        press(11, 5, 8'd255);
        press(11, 5, 8'd255);
        press(10, 5, 8'd239);
        press(11, 5, 8'd255);
        press(0, 5, 8'd0);
        press(10, 5, 8'd0);
        press(1, 5, 8'd28);
        press(10, 5, 8'd12);

        // Key 3 with an extra key added while down and a bouncing release.
        keys = 12'h008;
        push(3, 8'd84, cyc + 4);
        tick(5);
        keys = 12'h00A;
        tick(1);
        keys = '0;
        tick(1);
        keys = 12'h008;
        tick(1);
        keys = '0;
        tick(3);
        @(negedge clock);
        check("bounce_held_mid", 32'(held), 1);
        tick(1);
        @(negedge clock);
        check("bounce_held_end", 32'(held), 0);
        tick(4);

        // Reset during debounce, key kept held across it.
        keys = 12'h008;
        tick(2);
        #2 reset = 1'b0;
        #1;
        check("midrst_key_valid", 32'(key_valid), 0);
        check("midrst_key_code", 32'(key_code), 0);
        check("midrst_held", 32'(held), 0);
        check("midrst_duty", 32'(duty), 0);
        tick(2);
        reset = 1'b1;
        push(3, 8'd84, cyc + 4);
        tick(6);
        keys = '0;
        tick(10);

        check("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
